// File: rtl/cpu_ad48.sv
// cpu_ad48: single-cycle 48-bit core with an address register file (A),
// a data register file (D), combinational-read instruction and data memories
// and a sticky HALT. Optional build macro CPU_AD48_TRACE_EN adds a per-instruction
// trace print; without it the core is purely synthesizable logic.

// Word-addressed 48-bit memory: combinational read, clocked write, no reset,
// so contents survive reset and can be preloaded from outside.
module Ad48Mem #(
   parameter int WORDS = 64,
   parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [47:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [47:0]   rdata_o
);
   logic [47:0] mem [0:WORDS-1];

   assign rdata_o = mem[raddr_i];

   // Store the write word on the rising edge when enabled.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end
endmodule

// Eight 48-bit registers, one write port and one combinational read port.
// With ZERO_REG set, index 0 reads as zero and ignores writes.
module Ad48RegFile #(
   parameter bit ZERO_REG = 1'b0
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        we_i,
   input  logic [2:0]  waddr_i,
   input  logic [47:0] wdata_i,
   input  logic [2:0]  raddr_i,
   output logic [47:0] rdata_o
);
   logic [47:0] regs [0:7];

   assign rdata_o = (ZERO_REG && (raddr_i == 3'd0)) ? 48'd0 : regs[raddr_i];

   // Clear every register on reset; otherwise apply the single write port.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else if (we_i && !(ZERO_REG && (waddr_i == 3'd0))) begin
         regs[waddr_i] <= wdata_i;
      end
   end
endmodule

module cpu_ad48 #(
   parameter int IM_WORDS = 64,
   parameter int DM_WORDS = 64
) (
   input  logic clk,
   input  logic resetn
);
   localparam int IAW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;
   localparam int DAW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

   typedef enum logic [3:0] {
      OP_ALU    = 4'd0,
      OP_ALUI_A = 4'd1,
      OP_ALUI_D = 4'd2,
      OP_LD     = 4'd3,
      OP_ST     = 4'd4,
      OP_BZ     = 4'd5,
      OP_SYS    = 4'd15
   } opcode_e;

   typedef enum logic [3:0] {
      FN_ADD = 4'd0,
      FN_SUB = 4'd1,
      FN_AND = 4'd2,
      FN_OR  = 4'd3,
      FN_XOR = 4'd4,
      FN_SLL = 4'd5,
      FN_SRL = 4'd6,
      FN_SRA = 4'd7,
      FN_NOT = 4'd8
   } func_e;

   logic [IAW-1:0] pc_q, pc_d, pcSeq, pcBranch;
   logic           halt_q, halt_d;
   logic           halt;
   logic [47:0]    instr, imm;
   logic [3:0]     opcode, func;
   logic           dst, swap;
   logic [2:0]     rd, ra, rdx, dRaddr;
   logic [47:0]    aRdata, dRdata, op1, op2, aluResult, wbData, dmRdata, dmSum;
   logic [5:0]     shamt;
   logic [DAW-1:0] dmAddr;
   logic           aWe, dWe, dmWe;
   logic           unusedBits;

   assign halt = halt_q;

   assign opcode     = instr[47:44];
   assign dst        = instr[43];
   assign rd         = instr[42:40];
   assign ra         = instr[39:37];
   assign rdx        = instr[36:34];
   assign func       = instr[33:30];
   assign swap       = instr[29];
   assign imm        = {{21{instr[26]}}, instr[26:0]};
   assign unusedBits = ^instr[28:27];

   // ALUI_D sources its register operand from D[ra]; every other D read uses rdx.
   assign dRaddr = (opcode == OP_ALUI_D) ? ra : rdx;

   assign dmSum    = aRdata + imm;
   assign dmAddr   = DAW'(dmSum % 48'(DM_WORDS));
   assign pcSeq    = IAW'((48'(pc_q) + 48'd1) % 48'(IM_WORDS));
   assign pcBranch = IAW'((48'(pc_q) + 48'd1 + imm) % 48'(IM_WORDS));
   assign shamt    = op2[5:0];

   Ad48Mem #(.WORDS(IM_WORDS)) IMEM (
      .clk_i(clk), .we_i(1'b0), .waddr_i('0), .wdata_i('0),
      .raddr_i(pc_q), .rdata_o(instr)
   );

   Ad48Mem #(.WORDS(DM_WORDS)) DMEM (
      .clk_i(clk), .we_i(dmWe & resetn), .waddr_i(dmAddr), .wdata_i(dRdata),
      .raddr_i(dmAddr), .rdata_o(dmRdata)
   );

   Ad48RegFile #(.ZERO_REG(1'b1)) RF_A (
      .clk_i(clk), .resetn_i(resetn), .we_i(aWe), .waddr_i(rd),
      .wdata_i(wbData), .raddr_i(ra), .rdata_o(aRdata)
   );

   Ad48RegFile #(.ZERO_REG(1'b0)) RF_D (
      .clk_i(clk), .resetn_i(resetn), .we_i(dWe), .waddr_i(rd),
      .wdata_i(wbData), .raddr_i(dRaddr), .rdata_o(dRdata)
   );

   // Pick ALU operands: A/D pair (optionally swapped) or register plus immediate.
   always_comb begin
      op1 = aRdata;
      op2 = dRdata;
      case (opcode)
         OP_ALU: begin
            if (swap) begin
               op1 = dRdata;
               op2 = aRdata;
            end
         end
         OP_ALUI_A: op2 = imm;
         OP_ALUI_D: begin
            op1 = dRdata;
            op2 = imm;
         end
         default: ;
      endcase
   end

   // ALU; shifts of 48 or more saturate to zero or to the sign fill.
   always_comb begin
      aluResult = '0;
      case (func)
         FN_ADD: aluResult = op1 + op2;
         FN_SUB: aluResult = op1 - op2;
         FN_AND: aluResult = op1 & op2;
         FN_OR:  aluResult = op1 | op2;
         FN_XOR: aluResult = op1 ^ op2;
         FN_SLL: aluResult = (shamt >= 6'd48) ? 48'd0 : (op1 << shamt);
         FN_SRL: aluResult = (shamt >= 6'd48) ? 48'd0 : (op1 >> shamt);
         FN_SRA: aluResult = (shamt >= 6'd48) ? {48{op1[47]}}
                                              : $unsigned($signed(op1) >>> shamt);
         FN_NOT: aluResult = ~op1;
         default: aluResult = '0;
      endcase
   end

   // Decode write enables, writeback source, next PC and halt; nothing moves once halted.
   always_comb begin
      pc_d   = pc_q;
      halt_d = halt_q;
      aWe    = 1'b0;
      dWe    = 1'b0;
      dmWe   = 1'b0;
      wbData = aluResult;
      if (!halt_q) begin
         pc_d = pcSeq;
         case (opcode)
            OP_ALU, OP_ALUI_A, OP_ALUI_D: begin
               aWe = ~dst;
               dWe = dst;
            end
            OP_LD: begin
               aWe    = ~dst;
               dWe    = dst;
               wbData = dmRdata;
            end
            OP_ST: dmWe = 1'b1;
            OP_BZ: begin
               if (dRdata == 48'd0) begin
                  pc_d = pcBranch;
               end
            end
            OP_SYS: begin
               if (instr[3:0] == 4'hF) begin
                  halt_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // PC and sticky halt; reset restarts the program at word 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q   <= '0;
         halt_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         halt_q <= halt_d;
      end
   end

`ifdef CPU_AD48_TRACE_EN
   // Print every retired instruction and the state it writes.
   always @(posedge clk) begin
      if (resetn && !halt_q) begin
         $display("[TRACE] pc=%0d instr=%012h", pc_q, instr);
         if (aWe && (rd != 3'd0)) $display("[TRACE]    A%0d <= %012h", rd, wbData);
         if (dWe) $display("[TRACE]    D%0d <= %012h", rd, wbData);
         if (dmWe) $display("[TRACE]    DMEM[%0d] <= %012h", dmAddr, dRdata);
      end
   end
`endif
endmodule

// File: tb/tb_cpu_ad48.sv
// Scoreboard bench for cpu_ad48: each run preloads IMEM/DMEM during reset, an
// instruction-level reference model predicts the final architectural state,
// and a monitor compares it once the core halts.
module tb_cpu_ad48;
   localparam int IMW       = 64;
   localparam int DMW       = 64;
   localparam int BUDGET    = 300;
   localparam int MID_STEPS = 5;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   cpu_ad48 #(.IM_WORDS(IMW), .DM_WORDS(DMW)) dut (
      .clk(clk),
      .resetn(resetn)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      int          idx;
      logic [47:0] val;
   } expEntry_t;

   expEntry_t expQ[$];
   int        batchQ[$];
   int        total   = 0;
   int        bad     = 0;
   int        doneCnt = 0;
   int        runId   = 0;

   logic [47:0] prog    [0:IMW-1];
   logic [47:0] initMem [0:DMW-1];
   logic [47:0] mA      [0:7];
   logic [47:0] mD      [0:7];
   logic [47:0] mM      [0:DMW-1];
   bit          mHalt;

   // Shared comparison: counts every check, reports any difference.
   task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %012h expected %012h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] rand48();
      return {16'($urandom), $urandom};
   endfunction

   function automatic logic [47:0] enc(input int op, input int dst, input int rd, input int ra,
                                       input int rdx, input int fn, input int swp, input int imm);
      logic [47:0] w = '0;
      w[47:44] = 4'(op);
      w[43]    = 1'(dst);
      w[42:40] = 3'(rd);
      w[39:37] = 3'(ra);
      w[36:34] = 3'(rdx);
      w[33:30] = 4'(fn);
      w[29]    = 1'(swp);
      w[26:0]  = 27'(imm);
      return w;
   endfunction

   // Reference ALU written with 64-bit integer arithmetic.
   function automatic logic [47:0] aluRef(input int f, input logic [47:0] x, input logic [47:0] y);
      longint unsigned ux = 64'(x);
      longint          sx = longint'($signed(x));
      int              amt = int'(y[5:0]);
      case (f)
         0: return x + y;
         1: return x - y;
         2: return x & y;
         3: return x | y;
         4: return x ^ y;
         5: return 48'(ux << amt);
         6: return 48'(ux / (64'd1 << amt));
         7: return 48'(sx >>> amt);
         8: return ~x;
         default: return 48'd0;
      endcase
   endfunction

   task automatic writeReg(input int dst, input int rd, input logic [47:0] v);
      if (dst != 0) mD[rd] = v;
      else if (rd != 0) mA[rd] = v;
   endtask

   task automatic modelReset(input bit clearMem);
      for (int i = 0; i < 8; i++) begin
         mA[i] = '0;
         mD[i] = '0;
      end
      if (clearMem) for (int i = 0; i < DMW; i++) mM[i] = initMem[i];
   endtask

   // Instruction-level interpreter; stops at HALT or after maxSteps retirements.
   task automatic modelRun(input int maxSteps);
      int          pc = 0;
      int          steps = 0;
      int          op, dst, rd, ra, rdx, fn, addr;
      logic [47:0] w, imm, s;
      longint      t;
      mHalt = 0;
      while (!mHalt && steps < maxSteps) begin
         w   = prog[pc];
         op  = int'(w[47:44]);
         dst = int'(w[43]);
         rd  = int'(w[42:40]);
         ra  = int'(w[39:37]);
         rdx = int'(w[36:34]);
         fn  = int'(w[33:30]);
         imm = {{21{w[26]}}, w[26:0]};
         s   = mA[ra] + imm;
         addr = int'(s % DMW);
         steps++;
         t = longint'(pc) + 1;
         case (op)
            0: writeReg(dst, rd, w[29] ? aluRef(fn, mD[rdx], mA[ra]) : aluRef(fn, mA[ra], mD[rdx]));
            1: writeReg(dst, rd, aluRef(fn, mA[ra], imm));
            2: writeReg(dst, rd, aluRef(fn, mD[ra], imm));
            3: writeReg(dst, rd, mM[addr]);
            4: mM[addr] = mD[rdx];
            5: if (mD[rdx] == 48'd0) t = t + longint'($signed(imm));
            15: if (w[3:0] == 4'hF) mHalt = 1;
            default: ;
         endcase
         pc = int'(((t % IMW) + IMW) % IMW);
      end
   endtask

   task automatic pushE(input int kind, input int idx, input logic [47:0] val);
      expEntry_t e;
      e.kind = kind;
      e.idx  = idx;
      e.val  = val;
      expQ.push_back(e);
   endtask

   // Queue the model's full final state, plus hand-derived values for the directed program.
   task automatic pushState(input bit directed);
      int n = 0;
      for (int i = 0; i < 8; i++) begin
         pushE(0, i, mA[i]);
         pushE(1, i, mD[i]);
         n += 2;
      end
      for (int i = 0; i < DMW; i++) begin
         pushE(2, i, mM[i]);
         n++;
      end
      pushE(3, 0, 48'd1);
      n++;
      if (directed) begin
         pushE(0, 0, 48'd0);            pushE(0, 1, 48'd5);
         pushE(0, 2, 48'hFFFFFFFFFFFE); pushE(0, 3, 48'd10);
         pushE(0, 4, 48'd3);            pushE(0, 5, 48'd2);
         pushE(0, 6, 48'hFFFFFFFFFFFA); pushE(0, 7, 48'd17);
         pushE(1, 0, 48'd0);            pushE(1, 1, 48'd7);
         pushE(1, 2, 48'd12);           pushE(1, 3, 48'd5);
         pushE(1, 4, 48'd7);            pushE(1, 5, 48'd2);
         pushE(1, 6, 48'd7);            pushE(1, 7, 48'hFFFFFFFFFFFC);
         pushE(2, 3, 48'd7);
         n += 17;
      end
      batchQ.push_back(n);
   endtask

   function automatic logic [47:0] actualOf(input int kind, input int idx);
      case (kind)
         0: return dut.RF_A.regs[idx];
         1: return dut.RF_D.regs[idx];
         2: return dut.DMEM.mem[idx];
         default: return 48'(dut.halt);
      endcase
   endfunction

   task automatic drainBatch(input bit compare);
      int        n = batchQ.pop_front();
      expEntry_t e;
      string     kn;
      for (int i = 0; i < n; i++) begin
         e  = expQ.pop_front();
         kn = (e.kind == 0) ? "A" : (e.kind == 1) ? "D" : (e.kind == 2) ? "DMEM" : "halt";
         if (compare) checkOutput($sformatf("run%0d_%s[%0d]", runId, kn, e.idx),
                                  actualOf(e.kind, e.idx), e.val);
      end
      doneCnt++;
   endtask

   // Monitor: once the core halts, let a few more clocks pass, then check the frozen state.
   initial begin : monitor
      int cyc = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            cyc = 0;
         end else if (batchQ.size() != 0) begin
            cyc++;
            if (dut.halt === 1'b1) begin
               repeat (4) @(negedge clk);
               drainBatch(1'b1);
            end else if (cyc > BUDGET) begin
               total++;
               bad++;
               $display("[TB] FAIL run%0d_haltTimeout: no halt after %0d cycles, expected halt", runId, cyc);
               drainBatch(1'b0);
            end
         end
      end
   end

   task automatic checkResetState(input string tag);
      logic [47:0] acc = '0;
      #1;
      checkOutput({tag, "_halt"}, 48'(dut.halt), 48'd0);
      checkOutput({tag, "_pc"}, 48'(dut.pc_q), 48'd0);
      for (int i = 0; i < 8; i++) acc = acc | dut.RF_A.regs[i] | dut.RF_D.regs[i];
      checkOutput({tag, "_regs"}, acc, 48'd0);
   endtask

   task automatic fillFrom(input int start, input logic [47:0] w);
      for (int i = start; i < IMW; i++) prog[i] = w;
   endtask

   task automatic buildDirected();
      prog[0]  = enc(1, 0, 1, 0, 0, 0, 0, 5);
      prog[1]  = enc(2, 1, 1, 0, 0, 0, 0, 7);
      prog[2]  = enc(0, 1, 2, 1, 1, 0, 0, 0);
      prog[3]  = enc(0, 0, 2, 1, 1, 1, 0, 0);
      prog[4]  = enc(0, 1, 3, 1, 1, 2, 0, 0);
      prog[5]  = enc(0, 1, 4, 1, 1, 3, 0, 0);
      prog[6]  = enc(0, 1, 5, 1, 1, 4, 0, 0);
      prog[7]  = enc(1, 0, 3, 1, 0, 5, 0, 1);
      prog[8]  = enc(2, 0, 4, 1, 0, 6, 0, 1);
      prog[9]  = enc(0, 1, 7, 0, 1, 1, 0, 0);
      prog[10] = enc(2, 1, 7, 7, 0, 7, 0, 1);
      prog[11] = enc(1, 0, 6, 1, 0, 8, 0, 0);
      prog[12] = enc(1, 0, 0, 0, 0, 0, 0, 123);
      prog[13] = enc(0, 0, 7, 3, 1, 0, 1, 0);
      prog[14] = enc(1, 0, 5, 3, 0, 0, 0, -8);
      prog[15] = enc(4, 0, 0, 0, 1, 0, 0, 3);
      prog[16] = enc(3, 1, 6, 0, 0, 0, 0, DMW + 3);
      prog[17] = enc(5, 0, 0, 0, 1, 0, 0, -1);
      prog[18] = enc(5, 0, 0, 0, 0, 0, 0, 1);
      prog[19] = enc(1, 0, 1, 0, 0, 0, 0, 99);
      prog[20] = enc(15, 0, 0, 0, 0, 0, 0, 15);
      fillFrom(21, enc(1, 0, 2, 2, 0, 0, 0, 1));
   endtask

   task automatic genRandomProgram(input bit allowBranch);
      int          n = $urandom_range(20, 40);
      int          k;
      logic [47:0] w;
      for (int i = 0; i < n; i++) begin
         w = rand48();
         k = $urandom_range(0, 9);
         if (k == 6 && !allowBranch) k = 0;
         if ($urandom_range(0, 1) == 1) w[26:0] = 27'(int'($urandom_range(0, 140)) - 70);
         case (k)
            0, 1: w[47:44] = 4'd0;
            2: w[47:44] = 4'd1;
            3: w[47:44] = 4'd2;
            4: w[47:44] = 4'd3;
            5: w[47:44] = 4'd4;
            6: begin
               w[47:44] = 4'd5;
               w[26:0]  = 27'($urandom_range(0, n - 1 - i));
            end
            7: w[47:44] = 4'($urandom_range(6, 14));
            8: begin
               w[47:44] = 4'd15;
               w[3:0]   = 4'($urandom_range(0, 14));
            end
            default: begin
               w[47:44] = 4'd1;
               w[33:30] = 4'($urandom_range(5, 7));
               w[26:0]  = 27'($urandom_range(0, 63));
            end
         endcase
         prog[i] = w;
      end
      prog[n] = enc(15, 0, 0, 0, 0, 0, 0, 15);
      fillFrom(n + 1, enc(1, 0, 2, 2, 0, 0, 0, 1));
   endtask

   task automatic waitDone(input int prev);
      int g = 0;
      while (doneCnt == prev && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (doneCnt == prev) begin
         total++;
         bad++;
         $display("[TB] FAIL run%0d_monitor: monitor did not complete, expected completion", runId);
      end
   endtask

   // mode 0 directed, 1 random with branches, 2 random restarted by a mid-run reset, 3 BZ self-loop.
   task automatic applyStimulus(input int mode);
      int prev;
      @(negedge clk);
      resetn = 1'b0;
      checkResetState($sformatf("reset%0d", runId));
      runId++;
      for (int i = 0; i < DMW; i++) initMem[i] = rand48();
      case (mode)
         0: buildDirected();
         3: begin
            prog[0] = enc(5, 0, 0, 0, 0, 0, 0, -1);
            fillFrom(1, enc(15, 0, 0, 0, 0, 0, 0, 15));
         end
         default: genRandomProgram(mode == 1);
      endcase
      for (int i = 0; i < IMW; i++) dut.IMEM.mem[i] = prog[i];
      for (int i = 0; i < DMW; i++) dut.DMEM.mem[i] = initMem[i];
      if (mode != 3) begin
         modelReset(1'b1);
         if (mode == 2) begin
            modelRun(MID_STEPS);
            modelReset(1'b0);
         end
         modelRun(1000);
         pushState(mode == 0);
      end
      @(negedge clk);
      prev   = doneCnt;
      resetn = 1'b1;
      if (mode == 3) begin
         repeat (30) @(negedge clk);
         checkOutput("bzLoop_halt", 48'(dut.halt), 48'd0);
         checkOutput("bzLoop_pc", 48'(dut.pc_q), 48'd0);
      end else begin
         if (mode == 2) begin
            repeat (MID_STEPS) @(posedge clk);
            @(negedge clk);
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
         end
         waitDone(prev);
      end
   endtask

   initial begin
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(0);
      applyStimulus(3);
      for (int r = 0; r < 6; r++) applyStimulus(1);
      for (int r = 0; r < 2; r++) applyStimulus(2);
      @(negedge clk);
      resetn = 1'b0;
      checkResetState("final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
